// File: rtl/mini_src_io_pkg.sv
// Types and constants shared by the Mini SRC I/O blocks: the UART transmit
// state encoding and the word/byte geometry of the output-port serialiser.
package mini_src_io_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int DATA_BITS      = 8;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/outport_word_fifo.sv
// Small synchronous word FIFO with show-ahead read: rdata always presents the
// head entry so the transmitter can pop and load in the same cycle.
module outport_word_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [WIDTH-1:0]              wdata,
   input  logic                          pop,
   output logic [WIDTH-1:0]              rdata,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is only accepted when a pop frees the slot this cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/outport_uart_tx.sv
// Captures each new OUTPORTout value while the processor runs and sends it as
// four UART bytes, LSB first. Define OUTPORT_TX_PARITY_EN for an even-parity bit.
module outport_uart_tx
   import mini_src_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [31:0]                   OUTPORTout,
   input  logic                          run,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic [1:0]        BYTE_LAST = 2'(BYTES_PER_WORD - 1);

   tx_state_t         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [1:0]        byte_q, byte_d;
   logic [31:0]       shift_q, shift_d;
   logic              tx_q, tx_d;
   logic [31:0]       prev_word_q;
   logic              primed_q;
   logic              overflow_q;

   logic              capture;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [31:0]       fifo_rdata;
   logic              bit_done;
   logic [7:0]        cur_byte;

   // primed_q keeps the word present at reset release from looking like a new write.
   assign capture  = run && primed_q && (OUTPORTout != prev_word_q);
   assign bit_done = (baud_q == BAUD_LAST);

   outport_word_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (32)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (capture),
      .wdata (OUTPORTout),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;

      if (state_q != IDLE) begin
         baud_d = bit_done ? '0 : baud_q + BAUD_ONE;
      end

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               byte_d   = '0;
               baud_d   = '0;
               state_d  = START;
            end
         end
         START: begin
            if (bit_done) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_q == BIT_LAST) begin
`ifdef OUTPORT_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef OUTPORT_TX_PARITY_EN
         PARITY: begin
            if (bit_done) state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_done) begin
               if (byte_q != BYTE_LAST) begin
                  byte_d  = byte_q + 2'd1;
                  shift_d = {8'h00, shift_q[31:8]};
                  state_d = START;
               end else if (!fifo_empty) begin
                  // Chain straight into the next word with no idle bit.
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  byte_d   = '0;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // tx is decoded from the next state and registered so the line never glitches.
      cur_byte = shift_d[7:0];
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte[bit_d];
`ifdef OUTPORT_TX_PARITY_EN
         PARITY:  tx_d = even_parity(cur_byte);
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         shift_q     <= '0;
         tx_q        <= 1'b1;
         prev_word_q <= '0;
         primed_q    <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         prev_word_q <= OUTPORTout;
         primed_q    <= 1'b1;
         if (capture && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign tx       = tx_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/outport_uart_tx.md
# outport_uart_tx

Serial drain for the Mini SRC output port. The block sits outside the `mini_src_group_1` processor, beside the top level. It watches the processor's 32-bit `OUTPORTout` bus and captures each new value written while the processor runs. Captured words are queued in a small FIFO and each is sent as four 8N1 UART bytes, least significant byte first, so a bench or board can read program output on a single wire.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit, ≥2.
- `FIFO_DEPTH`, 4: captured words held; power of two, ≥2.
- `clk` input 1: system clock, the same clock as the processor.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `OUTPORTout` input 32: the processor output-port register value.
- `run` input 1: processor run flag; capture is enabled only while it is high.
- `tx` output 1: UART serial line; idles high.
- `busy` output 1: high when `state != IDLE` or the FIFO is non-empty.
- `overflow` output 1: sticky; set when a capture is dropped because the FIFO is full.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: number of words queued.

## Operation
- **Reset values**
  - `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, state=IDLE.
  - `prev_word`=0 and FIFO pointers=0.
- **Capture**
  - `prev_word` loads `OUTPORTout` on every edge.
  - The capture condition is `run && (OUTPORTout != prev_word)`; when true, the word is pushed on that edge.
  - A repeated write of the same value is not seen; this is an intended limitation.
- **Full FIFO**
  - A capture when full and not popping in the same cycle is dropped and sets `overflow`.
  - Only `reset` clears `overflow`.
  - A push and a pop in the same cycle when full is legal; the count is unchanged.
- **State machine states**: IDLE, START, DATA, PARITY (only with the config macro), STOP.
  - IDLE: if the FIFO is non-empty, pop a word into the shift register, set byte index to 0, go to START.
  - START: drive `tx`=0 for one bit time, then go to DATA.
  - DATA: drive 8 bits LSB first, one bit time each, then go to PARITY or STOP.
  - STOP: drive `tx`=1 for one bit time.
    - Byte index < 3: increment it, shift the word right 8 bits, go to START.
    - Last byte and FIFO non-empty: pop the next word, go to START with no idle bit.
    - Otherwise go to IDLE.
- **Byte order**: `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- **Counters**
  - The baud counter runs 0..`CLKS_PER_BIT`-1.
  - The bit index runs 0..7.
  - The byte index runs 0..3.
  - All counters wrap only through the state transitions above.

## Timing
- The rising edge that samples a new value is E0; the push happens on E0.
- The IDLE pop happens on E1, and `tx` falls after E1 (2-edge latency).
- Each bit holds exactly `CLKS_PER_BIT` cycles.
- One word takes 40·`CLKS_PER_BIT` cycles, or 44·`CLKS_PER_BIT` with parity.
- `busy` deasserts on the edge that ends the final stop bit, when the FIFO is empty.
- **Reset mid-frame**
  - The frame is aborted and the FIFO cleared.
  - `tx`=1 from the next edge.
  - The value on `OUTPORTout` at reset release is not captured unless it later changes.
- **Run low**: changes are tracked by `prev_word` but not queued; any frame in progress completes.

## Configuration
- Macro: `OUTPORT_TX_PARITY_EN`.
- Defined: PARITY state is present, with one even-parity bit (XOR of the 8 data bits) between the last data bit and stop. A frame is 11 bits.
- Undefined: the PARITY state and its logic are absent. A frame is 10 bits (8N1).

## Structure
- Shared package `mini_src_io_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - `BYTES_PER_WORD`=4.
  - `DATA_BITS`=8.
- Sub-module `outport_word_fifo`:
  - Synchronous FIFO with push, pop, full, empty and count.
  - Parameterised by `FIFO_DEPTH`.
  - Reset by `reset`.
- The top block holds capture, the state machine and the counters.

## Test plan
- `CLKS_PER_BIT`=4, `run`=1, `OUTPORTout`=0xA5C30F81 → bytes 0x81, 0x0F, 0xC3, 0xA5 appear on `tx`, 160 cycles total; `busy` then drops; `overflow`=0.
- Same value held 50 cycles, then rewritten with the same value → exactly one word transmitted.
- `run`=0 while `OUTPORTout` changes 0→0x12→0x34 → `tx` stays 1; `fifo_count`=0.
- Six distinct values on consecutive cycles, `FIFO_DEPTH`=4 → the first five are transmitted back-to-back in order, the sixth is dropped, `overflow`=1 until reset.
- `reset` asserted during byte 2 of a word → `tx`=1 and `fifo_count`=0 on the next edge; no partial byte afterwards.
- `OUTPORT_TX_PARITY_EN` defined, word 0x00000007 → byte 0x07 carries parity 1, the other bytes parity 0; 176 cycles at `CLKS_PER_BIT`=4.
